instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction-memory program loader for the single-cycle MIPS core: the encoding counterpart of the main opcode decoder. It accepts assembled instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words (R-type, LW, SW, BEQ, ADDI, J). It writes the words sequentially into instruction memory from address 0. It raises `done` when the program ends or memory fills, and `err` on an unsupported instruction kind.

## Interface
- `DEPTH`, 64: instruction-memory capacity in words; must be a power of two.
- `AW`, 6: word-address width; log2(DEPTH).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begins a load session at address 0; honoured only in IDLE or DONE.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept a bundle.
- `kind`  in  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J; 6–7 unsupported.
- `rs`, `rt`, `rd`, `shamt`  in  5 each  register and shift fields.
- `funct`  in  6  R-type function code.
- `imm`  in  16  immediate or branch offset.
- `target`  in  26  jump target.
- `last`  in  1  final instruction of the program.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  AW  word address.
- `mem_wd`  out  32  encoded instruction.
- `count`  out  AW+1  words written this session.
- `done`  out  1  session finished.
- `err`  out  1  sticky: an unsupported kind was received this session.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: `in_ready`=0.
  - `start`=1 → ACCEPT; clear `count`, `mem_addr`, `err`, `done`.
- ACCEPT: `in_ready`=1. A transfer occurs when `in_valid`&&`in_ready`.
  - Supported kind → latch the encoded word and go to WRITE.
  - Unsupported kind → set `err`; write nothing; `count` unchanged. Go to DONE if `last`=1, otherwise stay in ACCEPT.
- Encodings (MSB first):
  - RTYPE: {000000, rs, rt, rd, shamt, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
  - Fields not used by a kind are ignored.
- WRITE: `mem_we`=1 for exactly one cycle, with `mem_addr` and `mem_wd` stable. On exit, `count`+=1 and `mem_addr`+=1.
  - Next state is DONE if the latched `last`=1 or `count` reaches DEPTH; otherwise ACCEPT.
- DONE: `done`=1, `in_ready`=0, `mem_we`=0.
  - `count` and `err` hold.
  - `mem_addr` holds the next free address; wraps to 0 when full.
  - `start` → ACCEPT as from IDLE.
- `start` is ignored in ACCEPT and WRITE.
- Inputs are sampled only on the accepting edge; later changes do not affect the latched word.

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE. All outputs 0: `in_ready`, `mem_we`, `mem_addr`, `mem_wd`, `count`, `done`, `err`.
- Reset mid-WRITE: `mem_we` is 0 in the cycle after the reset edge; the pending word is discarded.
- A transfer at edge N gives `mem_we`=1 during cycle N..N+1. `in_ready` is 0 in that cycle and returns to 1 after edge N+1.
- Peak throughput: one word per 2 cycles.
- `last` transfer at edge N: write during N..N+1; `done`=1 from edge N+1.
- Full: the write to address DEPTH-1 leads to DONE with `count`=DEPTH, even when `last`=0.
- `start` in DONE at edge M: `done`=0 and `in_ready`=1 from edge M.
- `mem_wd` holds its last written value outside WRITE; it is 0 after reset.

## Test plan
- After reset: `start`, then ADDI rs=0 rt=8 imm=0x0005 with `last`=0 → `mem_we` pulse at addr 0, `mem_wd`=0x20080005, `count`=1, `in_ready` high again 2 cycles after the transfer.
- RTYPE rs=8 rt=9 rd=10 shamt=0 funct=0x20, then J target=0x0000010 with `last`=1 → words 0x01095020 at addr 0 and 0x08000010 at addr 1; `done`=1 with `count`=2.
- LW rs=29 rt=8 imm=0xFFFC, SW same fields, BEQ rs=8 rt=9 imm=0x0003 (`last`) → 0x8FA8FFFC, 0xAFA8FFFC, 0x11090003 at addrs 0–2.
- kind=7 mid-stream → `err`=1 and stays set, no `mem_we`, `count` unchanged, next valid word lands at the unskipped address. kind=6 with `last` → DONE without a write.
- DEPTH=4: 5 bundles with `last`=0 → 4 writes at addrs 0–3, DONE after the 4th, `in_ready`=0 for the 5th, `mem_addr`=0, `count`=4.
- `reset_n` low during WRITE → no `mem_we` after the reset edge, all outputs 0. A new `start` resumes loading at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs MIPS instruction fields into 32-bit words and loads them into instruction memory
module instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    kind,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    input  logic          last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state;
    state_t      state_nx;
    logic        last_q;
    logic        supported;
    logic        fire;
    logic        at_last_slot;
    logic [31:0] enc_word;

    always_comb begin
        enc_word  = 32'd0;
        supported = 1'b1;
        case (kind)
            3'd0:    enc_word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            3'd1:    enc_word = {OP_LW, rs, rt, imm};
            3'd2:    enc_word = {OP_SW, rs, rt, imm};
            3'd3:    enc_word = {OP_BEQ, rs, rt, imm};
            3'd4:    enc_word = {OP_ADDI, rs, rt, imm};
            3'd5:    enc_word = {OP_J, target};
            default: supported = 1'b0;
        endcase
    end

    assign fire         = in_valid && (state == S_ACCEPT);
    // The write in progress is the one that brings count up to DEPTH.
    assign at_last_slot = (count == (AW+1)'(DEPTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (fire) begin
                    if (supported)  state_nx = S_WRITE;
                    else if (last)  state_nx = S_DONE;
                end
            end
            S_WRITE: begin
                if (last_q || at_last_slot) state_nx = S_DONE;
                else                        state_nx = S_ACCEPT;
            end
            S_DONE: begin
                if (start) state_nx = S_ACCEPT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            mem_wd   <= '0;
            count    <= '0;
            err      <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mem_addr <= '0;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (fire) begin
                        if (supported) begin
                            mem_wd <= enc_word;
                            last_q <= last;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    count    <= count + (AW+1)'(1);
                    mem_addr <= mem_addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == S_ACCEPT);
    assign mem_we   = (state == S_WRITE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder (DEPTH=64 and DEPTH=4 instances)
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        last = 1'b0;

    logic        in_ready, mem_we, done, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [6:0]  count;

    logic        s_in_ready, s_mem_we, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wd;
    logic [2:0]  s_count;

    int tests = 0;
    int fails = 0;

    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          s_wa_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .target(target), .last(last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .count(count), .done(done), .err(err)
    );

    instr_encoder #(.DEPTH(4), .AW(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
        .target(target), .last(last), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd),
        .count(s_count), .done(s_done), .err(s_err)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(mem_wd);
        end
        if (s_mem_we) s_wa_q.push_back(int'(s_mem_addr));
    end

    function automatic logic [31:0] ref_word(input int k, input int a_rs, input int a_rt, input int a_rd,
                                             input int a_sh, input int a_fn, input int a_imm, input int a_tg);
        int unsigned op;
        case (k)
            0: return 32'((a_rs << 21) | (a_rt << 16) | (a_rd << 11) | (a_sh << 6) | a_fn);
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            default: return 32'((2 << 26) | a_tg);
        endcase
        return 32'((op << 26) | (a_rs << 21) | (a_rt << 16) | a_imm);
    endfunction

    task automatic scramble();
        in_valid = 1'b0;
        kind   = 3'($urandom);
        rs     = 5'($urandom);
        rt     = 5'($urandom);
        rd     = 5'($urandom);
        shamt  = 5'($urandom);
        funct  = 6'($urandom);
        imm    = 16'($urandom);
        target = 26'($urandom);
        last   = 1'($urandom);
    endtask

    task automatic send(input bit sel, input int k, input int a_rs, input int a_rt, input int a_rd,
                        input int a_sh, input int a_fn, input int a_imm, input int a_tg,
                        input bit a_last, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (sel ? s_in_ready : in_ready) begin
                kind = 3'(k); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd); shamt = 5'(a_sh);
                funct = 6'(a_fn); imm = 16'(a_imm); target = 26'(a_tg); last = a_last;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                scramble();
                ok = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic clear_q();
        wa_q.delete(); wd_q.delete(); s_wa_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready, mem_we, mem_addr, mem_wd, count, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d wd=%h cnt=%0d done=%b err=%b, expected all 0",
                     in_ready, mem_we, mem_addr, mem_wd, count, done, err);
        end
        tests++;
        if ({s_in_ready, s_mem_we, s_mem_addr, s_mem_wd, s_count, s_done, s_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_small: got nonzero outputs, expected all 0");
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_addi();
        bit ok;
        do_start();
        send(0, 4, 0, 8, 0, 0, 0, 16'h0005, 0, 0, ok);
        @(negedge clk);
        tests++;
        if ({mem_we, in_ready, mem_addr, mem_wd} !== {1'b1, 1'b0, 6'd0, 32'h20080005}) begin
            fails++;
            $display("FAIL addi_write: got we=%b rdy=%b addr=%0d wd=%h, expected we=1 rdy=0 addr=0 wd=20080005",
                     mem_we, in_ready, mem_addr, mem_wd);
        end
        @(negedge clk);
        tests++;
        if ({mem_we, in_ready, count, mem_addr} !== {1'b0, 1'b1, 7'd1, 6'd1}) begin
            fails++;
            $display("FAIL addi_after: got we=%b rdy=%b cnt=%0d addr=%0d, expected we=0 rdy=1 cnt=1 addr=1",
                     mem_we, in_ready, count, mem_addr);
        end
    endtask

    task automatic test_rtype_j();
        bit ok;
        do_reset();
        do_start();
        clear_q();
        send(0, 0, 8, 9, 10, 0, 6'h20, 0, 0, 0, ok);
        send(0, 5, 0, 0, 0, 0, 0, 0, 26'h0000010, 1, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 2 || wa_q[0] != 0 || wd_q[0] !== 32'h01095020 || wa_q[1] != 1 || wd_q[1] !== 32'h08000010) begin
            fails++;
            $display("FAIL rtype_j_words: got %0d writes, first addr=%0d wd=%h, expected 2 writes 01095020@0 08000010@1",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
        end
        tests++;
        if ({done, count, in_ready} !== {1'b1, 7'd2, 1'b0}) begin
            fails++;
            $display("FAIL rtype_j_done: got done=%b cnt=%0d rdy=%b, expected done=1 cnt=2 rdy=0", done, count, in_ready);
        end
    endtask

    task automatic test_lw_sw_beq();
        bit ok;
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h8FA8FFFC; exp_w[1] = 32'hAFA8FFFC; exp_w[2] = 32'h11090003;
        do_start();
        @(negedge clk);
        tests++;
        if ({done, in_ready, count, mem_addr} !== {1'b0, 1'b1, 7'd0, 6'd0}) begin
            fails++;
            $display("FAIL restart_from_done: got done=%b rdy=%b cnt=%0d addr=%0d, expected done=0 rdy=1 cnt=0 addr=0",
                     done, in_ready, count, mem_addr);
        end
        clear_q();
        send(0, 1, 29, 8, 0, 0, 0, 16'hFFFC, 0, 0, ok);
        send(0, 2, 29, 8, 0, 0, 0, 16'hFFFC, 0, 0, ok);
        send(0, 3, 8, 9, 0, 0, 0, 16'h0003, 0, 1, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 3) begin
            fails++;
            $display("FAIL lsb_count: got %0d writes, expected 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (wa_q[i] != i || wd_q[i] !== exp_w[i]) begin
                    fails++;
                    $display("FAIL lsb_word%0d: got %h@%0d, expected %h@%0d", i, wd_q[i], wa_q[i], exp_w[i], i);
                end
            end
        end
    endtask

    task automatic test_unsupported();
        bit ok;
        do_start();
        clear_q();
        send(0, 4, 1, 2, 0, 0, 0, 16'h1234, 0, 0, ok);
        send(0, 7, 3, 4, 5, 6, 7, 16'h5555, 26'h1, 0, ok);
        @(negedge clk);
        tests++;
        if ({err, mem_we, count, in_ready} !== {1'b1, 1'b0, 7'd1, 1'b1}) begin
            fails++;
            $display("FAIL unsup_mid: got err=%b we=%b cnt=%0d rdy=%b, expected err=1 we=0 cnt=1 rdy=1",
                     err, mem_we, count, in_ready);
        end
        send(0, 4, 5, 6, 0, 0, 0, 16'h00AA, 0, 0, ok);
        send(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 2 || wa_q[1] != 1 || wd_q[1] !== 32'h20A600AA) begin
            fails++;
            $display("FAIL unsup_skip: got %0d writes, expected 2 with 20A600AA@1", wa_q.size());
        end
        tests++;
        if ({done, err, count} !== {1'b1, 1'b1, 7'd2}) begin
            fails++;
            $display("FAIL unsup_last: got done=%b err=%b cnt=%0d, expected done=1 err=1 cnt=2", done, err, count);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] exp_q[$];
        bit exp_err = 0;
        int n = 24;
        do_reset();
        do_start();
        clear_q();
        for (int i = 0; i < n; i++) begin
            int k  = $urandom_range(0, 7);
            int a  = $urandom_range(0, 31), b = $urandom_range(0, 31), c = $urandom_range(0, 31);
            int sh = $urandom_range(0, 31), fn = $urandom_range(0, 63);
            int im = $urandom_range(0, 65535), tg = int'($urandom & 32'h03FF_FFFF);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(0, k, a, b, c, sh, fn, im, tg, i == n - 1, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL random_handshake: bundle %0d not accepted within bound", i);
            end
            if (k <= 5) exp_q.push_back(ref_word(k, a, b, c, sh, fn, im, tg));
            else exp_err = 1;
        end
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random_nwrites: got %0d, expected %0d", wa_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (wa_q[i] != i || wd_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random_word%0d: got %h@%0d, expected %h@%0d", i, wd_q[i], wa_q[i], exp_q[i], i);
                end
            end
        end
        tests++;
        if ({done, err, count} !== {1'b1, exp_err, 7'(exp_q.size())}) begin
            fails++;
            $display("FAIL random_final: got done=%b err=%b cnt=%0d, expected done=1 err=%b cnt=%0d",
                     done, err, count, exp_err, exp_q.size());
        end
    endtask

    task automatic test_depth_full();
        bit ok;
        do_reset();
        do_start();
        clear_q();
        for (int i = 0; i < 5; i++) begin
            send(1, 4, i, i + 1, 0, 0, 0, i, 0, 0, ok);
            tests++;
            if (ok !== (i < 4)) begin
                fails++;
                $display("FAIL full_accept%0d: got accepted=%b, expected %b", i, ok, i < 4);
            end
        end
        tests++;
        if (s_wa_q.size() != 4 || s_wa_q[0] != 0 || s_wa_q[3] != 3) begin
            fails++;
            $display("FAIL full_writes: got %0d writes, expected 4 at addrs 0-3", s_wa_q.size());
        end
        tests++;
        if ({s_done, s_in_ready, s_mem_addr, s_count} !== {1'b1, 1'b0, 2'd0, 3'd4}) begin
            fails++;
            $display("FAIL full_state: got done=%b rdy=%b addr=%0d cnt=%0d, expected done=1 rdy=0 addr=0 cnt=4",
                     s_done, s_in_ready, s_mem_addr, s_count);
        end
    endtask

    task automatic test_reset_write();
        bit ok;
        do_reset();
        do_start();
        send(0, 4, 1, 1, 0, 0, 0, 16'h7777, 0, 0, ok);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready, mem_we, mem_addr, mem_wd, count, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_in_write: got we=%b addr=%0d wd=%h cnt=%0d, expected all 0", mem_we, mem_addr, mem_wd, count);
        end
        reset_n = 1'b1;
        do_start();
        clear_q();
        send(0, 4, 0, 8, 0, 0, 0, 16'h0005, 0, 1, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (wa_q.size() != 1 || wa_q[0] != 0 || wd_q[0] !== 32'h20080005 || count !== 7'd1) begin
            fails++;
            $display("FAIL reset_resume: got %0d writes cnt=%0d, expected 20080005@0 cnt=1", wa_q.size(), count);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype_j();
        test_lw_sw_beq();
        test_unsupported();
        test_random();
        test_depth_full();
        test_reset_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
